// File: rtl/filter_ctrl_pkg.sv
// rtl/filter_ctrl_pkg.sv - shared state encoding, frame-size helper and timeout fill value for filter_frame_ctrl
package filter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Value written to the destination when the filter never answers.
    localparam int TIMEOUT_FILL = 0;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - loadable per-pixel wait counter with expiry flag at MAX_WAIT-1
// Ports: clk, rst_n (async active-low), load (clear count), en (count one WAIT cycle),
//        expired (count has reached MAX_WAIT-1)
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CW-1:0] count;

    // Holds at the expiry value so an unexpected extra enable cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/filter_frame_ctrl.sv
// rtl/filter_frame_ctrl.sv - frame sequencer feeding one single-pixel-handshake filter from a source to a destination frame buffer
// Ports: clk, rst_n (async active-low); start, abort control; busy, done, timeout_err, timeout_cnt status;
//        src_rd_* source RAM read; flt_* filter handshake; dst_wr_* destination RAM write;
//        frame_sum (only when FRAME_CHECKSUM_EN is defined) running sum of all written pixels.
module filter_frame_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 464,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 18,
    parameter int MAX_WAIT     = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [15:0]           timeout_cnt,
    output logic                  src_rd_en,
    output logic [ADDR_WIDTH-1:0] src_rd_addr,
    input  logic [DATA_WIDTH-1:0] src_rd_data,
    output logic                  flt_clr,
    output logic                  flt_pixel_valid,
    output logic [DATA_WIDTH-1:0] flt_pixel_in,
    input  logic                  flt_pixel_out_valid,
    input  logic [DATA_WIDTH-1:0] flt_pixel_out,
    output logic                  dst_wr_en,
    output logic [ADDR_WIDTH-1:0] dst_wr_addr,
    output logic [DATA_WIDTH-1:0] dst_wr_data
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [31:0]           frame_sum
`endif
);

    localparam int FRAME_PIXELS = frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  expired;
    logic                  pix_done;
    logic                  last_pix;
    logic                  start_frame;

    ctrl_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_q == ST_ISSUE),
        .en      (state_q == ST_WAIT),
        .expired (expired)
    );

    // Abort beats start in IDLE; a result or an expiry ends the pixel unless aborting.
    assign start_frame = (state_q == ST_IDLE) && start && !abort;
    assign pix_done    = (state_q == ST_WAIT) && (flt_pixel_out_valid || expired) && !abort;
    assign last_pix    = (idx == ADDR_WIDTH'(FRAME_PIXELS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_frame) state_d = ST_CLEAR;
                ST_CLEAR: state_d = ST_READ;
                ST_READ:  state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT:  if (pix_done) state_d = last_pix ? ST_DONE : ST_READ;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = (state_q != ST_IDLE);
        done            = (state_q == ST_DONE) && !abort;
        flt_clr         = (state_q == ST_CLEAR);
        src_rd_en       = (state_q == ST_READ);
        src_rd_addr     = (state_q == ST_READ) ? idx : '0;
        flt_pixel_valid = (state_q == ST_ISSUE);
        flt_pixel_in    = (state_q == ST_ISSUE) ? src_rd_data : '0;
        dst_wr_en       = pix_done;
        dst_wr_addr     = pix_done ? idx : '0;
        dst_wr_data     = '0;
        if (pix_done) begin
            dst_wr_data = flt_pixel_out_valid ? flt_pixel_out : DATA_WIDTH'(TIMEOUT_FILL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            timeout_err <= 1'b0;
            timeout_cnt <= '0;
        end else if (start_frame) begin
            idx         <= '0;
            timeout_err <= 1'b0;
            timeout_cnt <= '0;
        end else if (pix_done) begin
            if (!last_pix) begin
                idx <= idx + ADDR_WIDTH'(1);
            end
            if (!flt_pixel_out_valid) begin
                timeout_err <= 1'b1;
                if (timeout_cnt != 16'hFFFF) begin
                    timeout_cnt <= timeout_cnt + 16'd1;
                end
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_sum <= '0;
        end else if (start_frame) begin
            frame_sum <= '0;
        end else if (dst_wr_en) begin
            frame_sum <= frame_sum + 32'(dst_wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// tb/tb_filter_frame_ctrl.sv - directed scoreboard bench for filter_frame_ctrl with a stub filter
module tb_filter_frame_ctrl;

    localparam int IW = 4;
    localparam int IH = 3;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [15:0]   timeout_cnt;
    logic          src_rd_en;
    logic [AW-1:0] src_rd_addr;
    logic [DW-1:0] src_rd_data;
    logic          flt_clr;
    logic          flt_pixel_valid;
    logic [DW-1:0] flt_pixel_in;
    logic          flt_pixel_out_valid;
    logic [DW-1:0] flt_pixel_out;
    logic          dst_wr_en;
    logic [AW-1:0] dst_wr_addr;
    logic [DW-1:0] dst_wr_data;
`ifdef FRAME_CHECKSUM_EN
    logic [31:0]   frame_sum;
`endif

    filter_frame_ctrl #(
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MAX_WAIT     (MW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .busy                (busy),
        .done                (done),
        .timeout_err         (timeout_err),
        .timeout_cnt         (timeout_cnt),
        .src_rd_en           (src_rd_en),
        .src_rd_addr         (src_rd_addr),
        .src_rd_data         (src_rd_data),
        .flt_clr             (flt_clr),
        .flt_pixel_valid     (flt_pixel_valid),
        .flt_pixel_in        (flt_pixel_in),
        .flt_pixel_out_valid (flt_pixel_out_valid),
        .flt_pixel_out       (flt_pixel_out),
        .dst_wr_en           (dst_wr_en),
        .dst_wr_addr         (dst_wr_addr),
        .dst_wr_data         (dst_wr_data)
`ifdef FRAME_CHECKSUM_EN
        ,
        .frame_sum           (frame_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stimulus knobs for the stub filter.
    int   lat      = 1;
    int   drop_px  = -1;
    logic spur     = 1'b0;

    // Source RAM: pixel k holds value k, one-cycle read latency.
    always @(posedge clk) begin
        if (src_rd_en) src_rd_data <= DW'(src_rd_addr);
    end

    // Stub filter: returns in+1 after lat cycles; drops the pixel whose value equals drop_px.
    logic          stub_v;
    logic [DW-1:0] stub_d;
    logic [DW-1:0] pend_d;
    int            cd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_v <= 1'b0;
            stub_d <= '0;
            pend_d <= '0;
            cd     <= 0;
        end else begin
            stub_v <= 1'b0;
            if (flt_pixel_valid) begin
                if (int'(flt_pixel_in) != drop_px) begin
                    if (lat == 1) begin
                        stub_v <= 1'b1;
                        stub_d <= flt_pixel_in + 8'd1;
                    end else begin
                        cd     <= lat - 1;
                        pend_d <= flt_pixel_in + 8'd1;
                    end
                end
            end else if (cd > 1) begin
                cd <= cd - 1;
            end else if (cd == 1) begin
                cd     <= 0;
                stub_v <= 1'b1;
                stub_d <= pend_d;
            end
        end
    end
    assign flt_pixel_out_valid = stub_v | spur;
    assign flt_pixel_out       = stub_d;

    // Scoreboard of expected destination writes; gap is the expected cycle spacing from the previous write (0 = skip).
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gap;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   last_wr = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (dst_wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(dst_wr_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(dst_wr_data), 32'(mon_e.data));
                if (mon_e.gap != 0) chk("wr_gap", 32'(cyc - last_wr), 32'(mon_e.gap));
            end
            last_wr = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.addr = AW'(k);
            e.data = (k == drop_px) ? 8'd0 : DW'(k + 1);
            e.gap  = (k == 0) ? 0 : 2 + ((k == drop_px) ? MW : lat);
            sb.push_back(e);
        end
    endtask

    // Starts a frame and runs until busy falls; mode 1 adds start-while-busy and a spurious valid in READ.
    task automatic run_frame(input int mode, output int bcyc, output int dcnt, output int dpos);
        bcyc = 0;
        dcnt = 0;
        dpos = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            bcyc++;
            if (bcyc == 1) chk("flt_clr", 32'(flt_clr), 32'd1);
            if (done) begin
                dcnt++;
                dpos = bcyc;
            end
            if (mode == 1) begin
                start = (bcyc >= 3 && bcyc < 12);
                spur  = src_rd_en;
            end
            step();
        end
        start = 1'b0;
        spur  = 1'b0;
        chk("frame_end", 32'(busy), 32'd0);
    endtask

    int bc, dc, dp;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(src_rd_en), 32'd0);
        chk("rst_wr_en", 32'(dst_wr_en), 32'd0);
        chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        step();

        // Nominal frame.
        push_frame(IW * IH);
        run_frame(0, bc, dc, dp);
        chk("nom_cycles", 32'(bc), 32'd38);
        chk("nom_done_cnt", 32'(dc), 32'd1);
        chk("nom_done_pos", 32'(dp), 32'd38);
        chk("nom_sb_empty", 32'(sb.size()), 32'd0);
        chk("nom_terr", 32'(timeout_err), 32'd0);
`ifdef FRAME_CHECKSUM_EN
        chk("nom_frame_sum", frame_sum, 32'd78);
`endif

        // Timeout on pixel 5.
        drop_px = 5;
        push_frame(IW * IH);
        run_frame(0, bc, dc, dp);
        chk("to_cycles", 32'(bc), 32'd41);
        chk("to_done_cnt", 32'(dc), 32'd1);
        chk("to_terr", 32'(timeout_err), 32'd1);
        chk("to_tcnt", 32'(timeout_cnt), 32'd1);
        chk("to_sb_empty", 32'(sb.size()), 32'd0);
        drop_px = -1;

        // Latency exactly MAX_WAIT.
        lat = MW;
        push_frame(IW * IH);
        run_frame(0, bc, dc, dp);
        chk("lat_cycles", 32'(bc), 32'd74);
        chk("lat_tcnt", 32'(timeout_cnt), 32'd0);
        chk("lat_terr", 32'(timeout_err), 32'd0);
        chk("lat_sb_empty", 32'(sb.size()), 32'd0);
        lat = 1;

        // Start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);

        // Abort while waiting on pixel 7, after a timeout on pixel 5.
        drop_px = 5;
        push_frame(8 - 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (src_rd_en && src_rd_addr == AW'(7)) break;
            step();
        end
        chk("ab_reach_px7", 32'(src_rd_addr), 32'd7);
        step();
        step();
        abort = 1'b1;
        #1;
        chk("ab_wr_en", 32'(dst_wr_en), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_tcnt_kept", 32'(timeout_cnt), 32'd1);
        chk("ab_terr_kept", 32'(timeout_err), 32'd1);
        repeat (5) step();
        chk("ab_sb_empty", 32'(sb.size()), 32'd0);
        drop_px = -1;
        push_frame(IW * IH);
        run_frame(0, bc, dc, dp);
        chk("ab2_cycles", 32'(bc), 32'd38);
        chk("ab2_tcnt", 32'(timeout_cnt), 32'd0);
        chk("ab2_terr", 32'(timeout_err), 32'd0);
        chk("ab2_sb_empty", 32'(sb.size()), 32'd0);

        // Start while busy plus a spurious valid during READ.
        push_frame(IW * IH);
        run_frame(1, bc, dc, dp);
        chk("noise_cycles", 32'(bc), 32'd38);
        chk("noise_done_cnt", 32'(dc), 32'd1);
        chk("noise_sb_empty", 32'(sb.size()), 32'd0);
        repeat (3) step();
        chk("noise_idle", 32'(busy), 32'd0);

        // Reset in the middle of a frame.
        drop_px = 2;
        push_frame(IW * IH);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("mid_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rd_en", 32'(src_rd_en), 32'd0);
        chk("mr_pix_valid", 32'(flt_pixel_valid), 32'd0);
        chk("mr_wr_en", 32'(dst_wr_en), 32'd0);
        chk("mr_tcnt", 32'(timeout_cnt), 32'd0);
        chk("mr_terr", 32'(timeout_err), 32'd0);
        drop_px = -1;
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("mr_post_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
Frame sequencer for the single-pixel-handshake image filters (emboss and its siblings: pixel_valid/pixel_in in, pixel_out_valid/pixel_out back). On start it clears the filter, then walks a source frame buffer in raster order. It issues one pixel at a time, waits for the filter result under a bounded timeout, and writes each result to a destination frame buffer at the same address. Sits between the frame-buffer RAMs and one filter instance, replacing testbench-driven pixel sequencing.

Parameters:
IMAGE_WIDTH, 320, pixels per row
IMAGE_HEIGHT, 464, rows per frame
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 18, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT
MAX_WAIT, 100, max WAIT cycles per pixel before timeout

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
start  in  1  frame start request, sampled in IDLE only
abort  in  1  synchronous frame abort
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at frame completion
timeout_err  out  1  sticky; set on any pixel timeout, cleared at next frame start
timeout_cnt  out  16  timed-out pixels this frame, saturating at 0xFFFF
src_rd_en  out  1  source RAM read enable
src_rd_addr  out  ADDR_WIDTH  source RAM address
src_rd_data  in  DATA_WIDTH  source RAM data, valid 1 cycle after src_rd_en
flt_clr  out  1  one-cycle filter clear (line buffers) at frame start
flt_pixel_valid  out  1  pixel strobe to filter
flt_pixel_in  out  DATA_WIDTH  pixel to filter
flt_pixel_out_valid  in  1  filter result strobe
flt_pixel_out  in  DATA_WIDTH  filter result
dst_wr_en  out  1  destination RAM write enable
dst_wr_addr  out  ADDR_WIDTH  destination address
dst_wr_data  out  DATA_WIDTH  destination data

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. During reset, all outputs are 0, state is IDLE, and pixel index, wait counter, timeout_cnt and timeout_err are 0.
- States: IDLE, CLEAR, READ, ISSUE, WAIT, DONE.
- IDLE: start=1 -> CLEAR. Clear idx, timeout_cnt and timeout_err on that edge.
- CLEAR: flt_clr=1 for 1 cycle -> READ.
- READ: src_rd_en=1, src_rd_addr=idx -> ISSUE.
- ISSUE: flt_pixel_valid=1 and flt_pixel_in=src_rd_data for exactly this cycle. Clear the wait counter -> WAIT.
- WAIT, each cycle:
  - If flt_pixel_out_valid=1: in the same cycle drive dst_wr_en=1, dst_wr_addr=idx, dst_wr_data=flt_pixel_out.
  - Else if the wait counter = MAX_WAIT-1: write 0 to idx, set timeout_err, increment timeout_cnt (saturating).
  - Else: increment the wait counter and stay in WAIT.
  - After either write: if idx = IMAGE_WIDTH*IMAGE_HEIGHT-1 -> DONE; otherwise idx+1 -> READ.
- A valid arriving on the MAX_WAIT-th WAIT cycle is accepted, not timed out.
- DONE: done=1 for 1 cycle -> IDLE.
- Throughput: 2+L cycles per pixel for filter latency L>=1. For L=1 this is 3 cycles/pixel. Frame total = 1 (CLEAR) + N*(2+L) + 1 (DONE).
- flt_pixel_out_valid outside WAIT is ignored; nothing is written.
- start while busy is ignored. Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- abort=1 in any non-IDLE state -> IDLE next cycle. No done, no write in that cycle, timeout_err/timeout_cnt retain their values.
- Reset mid-frame: immediate return to reset values; the partial frame in the destination is undefined.
- dst_wr_*, flt_pixel_*, src_rd_* and flt_clr are all 0 whenever not asserted per the state rules above.

Optional Feature:
FRAME_CHECKSUM_EN:
- Defined: adds output frame_sum [31:0]. Cleared on the IDLE->CLEAR edge. Adds dst_wr_data on every dst write, including timeout fills; wraps modulo 2^32. Stable from the done pulse until the next start.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Package filter_ctrl_pkg:
  - state encoding constants (IDLE=0, CLEAR=1, READ=2, ISSUE=3, WAIT=4, DONE=5)
  - FRAME_PIXELS = IMAGE_WIDTH*IMAGE_HEIGHT helper
  - timeout fill value (0)
- One sub-module, ctrl_wait_timer: loadable wait counter that outputs an expired flag at count MAX_WAIT-1.

Test Plan:
Setup for all scenarios: IMAGE_WIDTH=4, IMAGE_HEIGHT=3, stub filter with latency L=1 returning in+1, source pixel k = k.
1. Nominal frame: one start pulse -> 12 dst writes, addr k with data k+1, each 3 cycles apart. done pulses once, 38 cycles after the start edge. timeout_err=0.
2. Timeout: stub drops output for pixel 5, MAX_WAIT=4 -> addr 5 written 0 on the 4th WAIT cycle. timeout_err=1, timeout_cnt=1, remaining pixels correct, done asserted.
3. Boundary: stub latency exactly MAX_WAIT=4 -> all 12 pixels accepted, no timeouts.
4. Abort at pixel 7 (in WAIT) -> busy low next cycle, no done, no further writes. A new start clears timeout_cnt and completes a full frame from addr 0.
5. start asserted while busy, plus a spurious flt_pixel_out_valid during READ -> neither has any effect; output matches scenario 1.
6. rst_n low mid-frame -> all outputs 0 asynchronously; after release, IDLE with busy=0. With FRAME_CHECKSUM_EN defined, scenario 1 gives frame_sum=78.
